pic_bus_sequencer: RTL and testbench

//  Sole bus master of the intel8259 PIC. After reset it issues the init word sequence
//  (ICW1, ICW2, ICW4, OCW1), then arbitrates three requesters: CPU interrupt acknowledge,
//  EOI commands and mask updates. Generates all PIC strobes and returns the vector.

---
 rtl/pic_seq_pkg.sv | 27 ++
 rtl/pic_strobe_timer.sv | 32 +++
 rtl/pic_bus_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pic_bus_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_seq_pkg.sv
// Shared types and constants for the 8259 PIC bus sequencer.
//   state_t   : sequencer FSM states
//   EOI_CMD   : non-specific end-of-interrupt command word
//   *_DEF     : default init words (ICW1, ICW2, ICW4, OCW1)
//   TMR_W     : width of the strobe dwell counter
package pic_seq_pkg;

   typedef enum logic [3:0] {
      INIT_SEL,
      IDLE,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      INTA1,
      INTA_GAP,
      INTA2,
      INTA_DONE
   } state_t;

   localparam logic [7:0] EOI_CMD  = 8'h20;
   localparam logic [7:0] ICW1_DEF = 8'h13;
   localparam logic [7:0] ICW2_DEF = 8'h08;
   localparam logic [7:0] ICW4_DEF = 8'h09;
   localparam logic [7:0] OCW1_DEF = 8'h00;
   localparam int         TMR_W    = 4;

endpackage

// File: rtl/pic_strobe_timer.sv
// Loadable down-counter that times how long a strobe phase dwells.
//   clk, rst : clock, async active-high reset
//   load     : load load_val this clock (overrides counting)
//   load_val : dwell length in clocks (>=1)
//   done     : high during the last clock of the dwell
module pic_strobe_timer
   import pic_seq_pkg::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   // cnt holds N on the first clock of an N-clock dwell, so 1 marks the last one
   assign done = (cnt == W'(1));

endmodule

// File: rtl/pic_bus_sequencer.sv
// Sole bus master of an 8259 PIC: runs the init word sequence after reset,
// then arbitrates interrupt acknowledge, EOI and mask-update requests.
//   clk, rst            : clock, async active-high reset
//   pic_cs_n/wr_n/rd_n  : PIC chip select / write / read strobes
//   pic_a0, pic_dout    : PIC register select and write data
//   pic_doe             : drive enable for pic_dout onto the shared bus
//   pic_din             : data from the PIC bus (vector during INTA2)
//   pic_inta_n, pic_int : interrupt acknowledge out, PIC interrupt in
//   ack_req             : CPU acknowledge request, level until vec_valid
//   vec, vec_valid      : captured vector and its one-clock strobe
//   eoi_req             : pulse requesting a non-specific EOI
//   mask_wr, mask_data  : pulse requesting an OCW1 write of mask_data
//   init_done, busy     : init sequence finished / bus cycle in progress
module pic_bus_sequencer
   import pic_seq_pkg::*;
#(
   parameter logic [7:0] ICW1      = ICW1_DEF,
   parameter logic [7:0] ICW2      = ICW2_DEF,
   parameter logic [7:0] ICW4      = ICW4_DEF,
   parameter logic [7:0] OCW1_INIT = OCW1_DEF,
   parameter int         PULSE_LEN = 3,
   parameter int         GAP_LEN   = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pic_cs_n,
   output logic       pic_wr_n,
   output logic       pic_rd_n,
   output logic       pic_a0,
   output logic [7:0] pic_dout,
   output logic       pic_doe,
   input  logic [7:0] pic_din,
   output logic       pic_inta_n,
   input  logic       pic_int,
   input  logic       ack_req,
   output logic [7:0] vec,
   output logic       vec_valid,
   input  logic       eoi_req,
   input  logic       mask_wr,
   input  logic [7:0] mask_data,
   output logic       init_done,
   output logic       busy
);

   state_t           state, state_nx;
   logic             tmr_load, tmr_done;
   logic [TMR_W-1:0] tmr_val;
   logic             grant_eoi, grant_mask, init_step, init_fin;
   logic [1:0]       init_idx;
   logic [1:0]       eoi_cnt;
   logic             mask_pend;
   logic [7:0]       mask_q;
   logic             wr_a0;
   logic [7:0]       wr_data;
   logic             in_wr;

   pic_strobe_timer #(.W(TMR_W)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT_SEL;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      grant_eoi  = 1'b0;
      grant_mask = 1'b0;
      init_step  = 1'b0;
      init_fin   = 1'b0;
      case (state)
         INIT_SEL: state_nx = WR_SETUP;
         IDLE: begin
            if (ack_req && pic_int) begin
               state_nx = INTA1;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(PULSE_LEN);
            end else if (eoi_cnt != 2'd0) begin
               grant_eoi = 1'b1;
               state_nx  = WR_SETUP;
            end else if (mask_pend) begin
               grant_mask = 1'b1;
               state_nx   = WR_SETUP;
            end
         end
         WR_SETUP: begin
            state_nx = WR_STROBE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(PULSE_LEN);
         end
         WR_STROBE: if (tmr_done) state_nx = WR_HOLD;
         WR_HOLD: begin
            if (init_done) begin
               state_nx = IDLE;
            end else if (init_idx == 2'd3) begin
               init_fin = 1'b1;
               state_nx = IDLE;
            end else begin
               init_step = 1'b1;
               state_nx  = INIT_SEL;
            end
         end
         INTA1: if (tmr_done) begin
            state_nx = INTA_GAP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(GAP_LEN);
         end
         INTA_GAP: if (tmr_done) begin
            state_nx = INTA2;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(PULSE_LEN);
         end
         INTA2:     if (tmr_done) state_nx = INTA_DONE;
         INTA_DONE: state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_idx  <= 2'd0;
         init_done <= 1'b0;
         eoi_cnt   <= 2'd0;
         mask_pend <= 1'b0;
         mask_q    <= 8'h00;
         wr_a0     <= 1'b0;
         wr_data   <= 8'h00;
         vec       <= 8'h00;
         busy      <= 1'b0;
      end else begin
         if (init_step) init_idx  <= init_idx + 2'd1;
         if (init_fin)  init_done <= 1'b1;

         // Simultaneous request and service cancel out, even when saturated
         case ({eoi_req, grant_eoi})
            2'b10:   if (eoi_cnt != 2'd3) eoi_cnt <= eoi_cnt + 2'd1;
            2'b01:   eoi_cnt <= eoi_cnt - 2'd1;
            default: ;
         endcase

         // A mask_wr coinciding with a grant re-arms pending with the newer data
         if (mask_wr) begin
            mask_pend <= 1'b1;
            mask_q    <= mask_data;
         end else if (grant_mask) begin
            mask_pend <= 1'b0;
         end

         if (state == INIT_SEL) begin
            wr_a0 <= (init_idx != 2'd0);
            case (init_idx)
               2'd0:    wr_data <= ICW1;
               2'd1:    wr_data <= ICW2;
               2'd2:    wr_data <= ICW4;
               default: wr_data <= OCW1_INIT;
            endcase
         end else if (grant_eoi) begin
            wr_a0   <= 1'b0;
            wr_data <= EOI_CMD;
         end else if (grant_mask) begin
            wr_a0   <= 1'b1;
            wr_data <= mask_q;
         end

         if (state == INTA2 && tmr_done) vec <= pic_din;

         // Registered so it reads 0 while reset holds the FSM in INIT_SEL
         busy <= (state_nx != IDLE) && !(state_nx == INIT_SEL && init_done);
      end
   end

   // Strobes decode straight from the state register so reset releases them at once
   assign in_wr      = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
   assign pic_cs_n   = !(in_wr || state == INTA2);
   assign pic_wr_n   = (state != WR_STROBE);
   assign pic_rd_n   = (state != INTA2);
   assign pic_inta_n = !(state == INTA1 || state == INTA2);
   assign pic_doe    = in_wr;
   assign pic_a0     = in_wr && wr_a0;
   assign pic_dout   = wr_data;
   assign vec_valid  = (state == INTA_DONE);

endmodule

// File: tb/tb_pic_bus_sequencer.sv
module tb_pic_bus_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_doe, pic_inta_n;
   logic [7:0] pic_dout, pic_din, vec;
   logic       pic_int, ack_req, vec_valid, eoi_req, mask_wr, init_done, busy;
   logic [7:0] mask_data;
   logic [7:0] pic_vec = 8'h0B;   // ICW2 base 08 + IRQ3

   always #5 clk = ~clk;

   // PIC model: drives the vector while the read strobe is low
   assign pic_din = (!pic_rd_n) ? pic_vec : 8'h00;

   pic_bus_sequencer dut (
      .clk(clk), .rst(rst),
      .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n), .pic_rd_n(pic_rd_n),
      .pic_a0(pic_a0), .pic_dout(pic_dout), .pic_doe(pic_doe), .pic_din(pic_din),
      .pic_inta_n(pic_inta_n), .pic_int(pic_int), .ack_req(ack_req),
      .vec(vec), .vec_valid(vec_valid), .eoi_req(eoi_req),
      .mask_wr(mask_wr), .mask_data(mask_data),
      .init_done(init_done), .busy(busy)
   );

   int n_chk = 0;
   int n_fail = 0;
   int n_wr = 0;
   logic [8:0] exp_wr[$];   // {a0, data}
   logic [7:0] exp_vec[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor, sampled on the falling edge
   int         wlen = 0, ilen = 0, iph = 0, igap = 0;
   logic [8:0] w_cap;
   logic [1:0] w_ctl;
   logic [8:0] w_exp;
   logic [7:0] v_exp;

   always @(negedge clk) begin
      if (rst) begin
         wlen = 0; ilen = 0; iph = 0; igap = 0;
      end else begin
         if (!pic_wr_n) begin
            wlen++;
            w_cap = {pic_a0, pic_dout};
            w_ctl = {pic_cs_n, pic_doe};
         end else if (wlen > 0) begin
            check("wr_len", wlen, 3);
            check("wr_cs_doe", w_ctl, 2'b01);
            n_wr++;
            check("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
               w_exp = exp_wr.pop_front();
               check("wr_a0_data", w_cap, w_exp);
            end
            wlen = 0;
         end
         if (!pic_inta_n) begin
            if (iph == 1 && igap > 0) begin
               check("inta_gap", igap, 1);
               igap = 0;
            end
            ilen++;
         end else if (ilen > 0) begin
            check("inta_len", ilen, 3);
            ilen = 0;
            if (iph == 0) begin iph = 1; igap = 1; end
            else iph = 0;
         end else if (iph == 1) begin
            igap++;
         end
         if (vec_valid) begin
            check("vec_expected", exp_vec.size() != 0, 1);
            if (exp_vec.size() != 0) begin
               v_exp = exp_vec.pop_front();
               check("vec", vec, v_exp);
            end
         end
      end
   end

   task automatic push_init();
      exp_wr.push_back({1'b0, 8'h13});
      exp_wr.push_back({1'b1, 8'h08});
      exp_wr.push_back({1'b1, 8'h09});
      exp_wr.push_back({1'b1, 8'h00});
   endtask

   task automatic wait_init(input string tag);
      int t = 0;
      while (!init_done && t < 100) begin @(negedge clk); t++; end
      check(tag, init_done, 1);
   endtask

   // Idle for three straight clocks means nothing is left pending
   task automatic wait_quiet(input string tag);
      int q = 0, t = 0;
      while (q < 3 && t < 200) begin
         @(negedge clk); t++;
         if (!busy) q++; else q = 0;
      end
      check(tag, q >= 3, 1);
   endtask

   task automatic wait_vec(input string tag, output int lat);
      int t = 0;
      do begin @(negedge clk); t++; end while (!vec_valid && t < 50);
      check(tag, vec_valid, 1);
      lat = t;
   endtask

   int base, lat, t;

   initial begin
      rst = 1'b1; ack_req = 0; pic_int = 0; eoi_req = 0; mask_wr = 0; mask_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_strobes", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n}, 4'hF);
      check("rst_flags", {pic_a0, pic_doe, vec_valid, init_done, busy}, 5'b0);
      check("rst_dout", pic_dout, 8'h00);
      check("rst_vec", vec, 8'h00);

      // 1. init sequence
      push_init();
      rst = 1'b0;
      @(negedge clk);
      check("init_busy", busy, 1);
      wait_init("init_done");
      wait_quiet("quiet_init");
      check("init_writes", n_wr, 4);

      // 2. ack held while pic_int low, then a full INTA cycle
      ack_req = 1'b1;
      repeat (4) @(negedge clk);
      check("ack_wait_noint", busy, 0);
      exp_vec.push_back(8'h0B);
      pic_int = 1'b1;
      wait_vec("vec_seen_2", lat);
      check("inta_latency", lat, 8);
      ack_req = 1'b0;
      wait_quiet("quiet_2");

      // 3. eoi and ack together: INTA wins, EOI follows
      base = n_wr;
      exp_vec.push_back(8'h0B);
      exp_wr.push_back({1'b0, 8'h20});
      ack_req = 1'b1; eoi_req = 1'b1;
      @(negedge clk); eoi_req = 1'b0;
      wait_vec("vec_seen_3", lat);
      check("eoi_after_inta", n_wr, base);
      ack_req = 1'b0;
      wait_quiet("quiet_3");
      check("eoi_count_3", n_wr, base + 1);

      // 4. four EOI pulses saturate at three writes
      base = n_wr;
      exp_vec.push_back(8'h0B);
      repeat (3) exp_wr.push_back({1'b0, 8'h20});
      ack_req = 1'b1;
      @(negedge clk);
      eoi_req = 1'b1;
      repeat (4) @(negedge clk);
      eoi_req = 1'b0;
      wait_vec("vec_seen_4", lat);
      ack_req = 1'b0;
      wait_quiet("quiet_4");
      check("eoi_sat_count", n_wr, base + 3);

      // 5. two mask updates while busy: only the last one is written
      base = n_wr;
      exp_vec.push_back(8'h0B);
      exp_wr.push_back({1'b1, 8'h0F});
      ack_req = 1'b1;
      @(negedge clk);
      mask_wr = 1'b1; mask_data = 8'hF0;
      @(negedge clk);
      mask_data = 8'h0F;
      @(negedge clk);
      mask_wr = 1'b0;
      wait_vec("vec_seen_5", lat);
      ack_req = 1'b0;
      wait_quiet("quiet_5");
      check("mask_count", n_wr, base + 1);

      // 6. reset in the middle of INTA2
      ack_req = 1'b1;
      t = 0;
      while (pic_rd_n && t < 30) begin @(negedge clk); t++; end
      check("reached_inta2", pic_rd_n, 0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_strobes", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n}, 4'hF);
      check("rst_mid_init", init_done, 0);
      ack_req = 1'b0;
      repeat (2) @(negedge clk);
      base = n_wr;
      push_init();
      rst = 1'b0;
      wait_init("reinit_done");
      wait_quiet("quiet_6");
      check("reinit_writes", n_wr, base + 4);

      check("wr_queue_empty", exp_wr.size(), 0);
      check("vec_queue_empty", exp_vec.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
